// File: rtl/rf_hazard_pkg.sv
// Shared types for the register-file hazard scoreboard: in-flight destination
// tags and the EX forwarding-select encoding.
package rf_hazard_pkg;

    localparam int TAG_STAGES = 3;
    localparam int RA_W       = 5;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            is_load;
    } rf_tag_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/rf_hazard_scoreboard_src_match.sv
// Youngest-producer priority encoder for one ID source operand against the
// EX/MEM/WB tags (index 0 = EX is youngest).
module rf_src_match
    import rf_hazard_pkg::*;
(
    input  logic                       i_used,
    input  logic [RA_W-1:0]            i_addr,
    input  rf_tag_t [TAG_STAGES-1:0]   i_tags,
    output logic                       o_hit,
    output logic [1:0]                 o_stage,
    output logic                       o_is_load
);

    always_comb begin
        o_hit     = 1'b0;
        o_stage   = 2'd0;
        o_is_load = 1'b0;
        // Walk oldest to youngest so a younger match overrides an older one.
        for (int k = TAG_STAGES - 1; k >= 0; k--) begin
            if (i_used && (i_addr != '0) && i_tags[k].valid && i_tags[k].we &&
                (i_tags[k].rd == i_addr)) begin
                o_hit     = 1'b1;
                o_stage   = 2'(k);
                o_is_load = i_tags[k].is_load;
            end
        end
    end

endmodule

// File: rtl/rf_hazard_scoreboard.sv
// Hazard controller for the RV32I register file: tracks EX/MEM/WB destination
// tags, produces the ID stall, EX forwarding selects, WB bypass and RF write port.
module rf_hazard_scoreboard
    import rf_hazard_pkg::*;
#(
    parameter int FORWARD_EN = 1,
    parameter int NREGS      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pipe_adv,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1_addr,
    input  logic             id_rs1_used,
    input  logic [RA_W-1:0]  id_rs2_addr,
    input  logic             id_rs2_used,
    input  logic [RA_W-1:0]  id_rd_addr,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    output logic             stall,
    output logic             id_rs1_wb_bypass,
    output logic             id_rs2_wb_bypass,
    output logic [1:0]       ex_fwd_rs1_sel,
    output logic [1:0]       ex_fwd_rs2_sel,
    output logic             rf_wr_en,
    output logic [RA_W-1:0]  rf_wr_addr,
    output logic [NREGS-1:0] busy_vec
);

    rf_tag_t [TAG_STAGES-1:0] r_tags;
    fwd_sel_e                 r_fwd1;
    fwd_sel_e                 r_fwd2;

    rf_tag_t    w_id_tag;
    logic       w_hit1, w_hit2, w_ld1, w_ld2, w_accept;
    logic [1:0] w_stg1, w_stg2;
    fwd_sel_e   w_fwd1, w_fwd2;

    function automatic fwd_sel_e sel_of(input logic hit, input logic [1:0] stg);
        if (FORWARD_EN == 0 || !hit) return FWD_NONE;
        if (stg == 2'd0)             return FWD_MEM;
        if (stg == 2'd1)             return FWD_WB;
        return FWD_NONE;
    endfunction

    rf_src_match u_rs1 (
        .i_used    (id_rs1_used),
        .i_addr    (id_rs1_addr),
        .i_tags    (r_tags),
        .o_hit     (w_hit1),
        .o_stage   (w_stg1),
        .o_is_load (w_ld1)
    );

    rf_src_match u_rs2 (
        .i_used    (id_rs2_used),
        .i_addr    (id_rs2_addr),
        .i_tags    (r_tags),
        .o_hit     (w_hit2),
        .o_stage   (w_stg2),
        .o_is_load (w_ld2)
    );

    // x0 is never a real destination, so its write-enable is dropped at entry.
    always_comb begin
        w_id_tag         = '0;
        w_id_tag.valid   = 1'b1;
        w_id_tag.rd      = id_rd_addr;
        w_id_tag.we      = id_rd_we && (id_rd_addr != '0);
        w_id_tag.is_load = id_is_load;
    end

    always_comb begin
        if (FORWARD_EN != 0)
            stall = id_valid && ((w_hit1 && w_stg1 == 2'd0 && w_ld1) ||
                                 (w_hit2 && w_stg2 == 2'd0 && w_ld2));
        else
            stall = id_valid && (w_hit1 || w_hit2);
    end

    assign w_accept         = id_valid && !stall && !flush;
    assign w_fwd1           = sel_of(w_hit1, w_stg1);
    assign w_fwd2           = sel_of(w_hit2, w_stg2);
    assign id_rs1_wb_bypass = w_hit1 && (w_stg1 == 2'd2);
    assign id_rs2_wb_bypass = w_hit2 && (w_stg2 == 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tags <= '0;
            r_fwd1 <= FWD_NONE;
            r_fwd2 <= FWD_NONE;
        end else if (pipe_adv) begin
            r_tags[2] <= r_tags[1];
            r_tags[1] <= r_tags[0];
            r_tags[0] <= w_accept ? w_id_tag : '0;
            r_fwd1    <= w_accept ? w_fwd1 : FWD_NONE;
            r_fwd2    <= w_accept ? w_fwd2 : FWD_NONE;
        end
    end

    assign ex_fwd_rs1_sel = r_fwd1;
    assign ex_fwd_rs2_sel = r_fwd2;
    assign rf_wr_en       = r_tags[2].valid && r_tags[2].we && pipe_adv;
    assign rf_wr_addr     = r_tags[2].rd;

    always_comb begin
        busy_vec = '0;
        for (int k = 0; k < TAG_STAGES; k++) begin
            if (r_tags[k].valid && r_tags[k].we) busy_vec[r_tags[k].rd] = 1'b1;
        end
        busy_vec[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// Self-checking bench: a forwarding and a non-forwarding scoreboard driven in
// parallel, each compared against its own behavioural pipeline model.
module tb_rf_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, pipe_adv, flush, id_valid;
    logic       rs1_used, rs2_used, rd_we, is_load;
    logic [4:0] rs1, rs2, rd;

    logic [1:0]       stall_o, byp1_o, byp2_o, wen_o;
    logic [1:0][1:0]  sel1_o, sel2_o;
    logic [1:0][4:0]  wad_o;
    logic [1:0][31:0] busy_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } mtag_t;

    mtag_t m[2][3];
    int    msel1[2];
    int    msel2[2];

    rf_hazard_scoreboard #(.FORWARD_EN(1), .NREGS(32)) u_fwd (
        .clk(clk), .reset_n(reset_n), .pipe_adv(pipe_adv), .flush(flush),
        .id_valid(id_valid), .id_rs1_addr(rs1), .id_rs1_used(rs1_used),
        .id_rs2_addr(rs2), .id_rs2_used(rs2_used), .id_rd_addr(rd),
        .id_rd_we(rd_we), .id_is_load(is_load), .stall(stall_o[0]),
        .id_rs1_wb_bypass(byp1_o[0]), .id_rs2_wb_bypass(byp2_o[0]),
        .ex_fwd_rs1_sel(sel1_o[0]), .ex_fwd_rs2_sel(sel2_o[0]),
        .rf_wr_en(wen_o[0]), .rf_wr_addr(wad_o[0]), .busy_vec(busy_o[0])
    );

    rf_hazard_scoreboard #(.FORWARD_EN(0), .NREGS(32)) u_nofwd (
        .clk(clk), .reset_n(reset_n), .pipe_adv(pipe_adv), .flush(flush),
        .id_valid(id_valid), .id_rs1_addr(rs1), .id_rs1_used(rs1_used),
        .id_rs2_addr(rs2), .id_rs2_used(rs2_used), .id_rd_addr(rd),
        .id_rd_we(rd_we), .id_is_load(is_load), .stall(stall_o[1]),
        .id_rs1_wb_bypass(byp1_o[1]), .id_rs2_wb_bypass(byp2_o[1]),
        .ex_fwd_rs1_sel(sel1_o[1]), .ex_fwd_rs2_sel(sel2_o[1]),
        .rf_wr_en(wen_o[1]), .rf_wr_addr(wad_o[1]), .busy_vec(busy_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Index of the youngest in-flight writer of addr (0 = EX), or -1.
    function automatic int ymatch(input int c, input bit used, input int addr);
        if (!used || addr == 0) return -1;
        for (int k = 0; k < 3; k++)
            if (m[c][k].v && m[c][k].we && m[c][k].rd == addr) return k;
        return -1;
    endfunction

    function automatic int fsel(input int c, input int s);
        if (c == 1) return 0;
        if (s == 0) return 1;
        if (s == 1) return 2;
        return 0;
    endfunction

    function automatic bit mstall(input int c);
        int s1 = ymatch(c, rs1_used, int'(rs1));
        int s2 = ymatch(c, rs2_used, int'(rs2));
        if (!id_valid) return 1'b0;
        if (c == 0) return (s1 == 0 && m[c][0].ld) || (s2 == 0 && m[c][0].ld);
        return (s1 >= 0) || (s2 >= 0);
    endfunction

    function automatic logic [31:0] mbusy(input int c);
        logic [31:0] b = '0;
        for (int k = 0; k < 3; k++)
            if (m[c][k].v && m[c][k].we && m[c][k].rd != 0) b[m[c][k].rd] = 1'b1;
        return b;
    endfunction

    task automatic mreset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) m[c][k] = '{v: 0, rd: 0, we: 0, ld: 0};
            msel1[c] = 0;
            msel2[c] = 0;
        end
    endtask

    task automatic check_all(input string ph);
        for (int c = 0; c < 2; c++) begin
            int  s1  = ymatch(c, rs1_used, int'(rs1));
            int  s2  = ymatch(c, rs2_used, int'(rs2));
            bit  wen = m[c][2].v && m[c][2].we && pipe_adv;
            chk($sformatf("%s_c%0d_stall", ph, c), 32'(stall_o[c]), 32'(mstall(c)));
            chk($sformatf("%s_c%0d_byp1", ph, c), 32'(byp1_o[c]), 32'(s1 == 2));
            chk($sformatf("%s_c%0d_byp2", ph, c), 32'(byp2_o[c]), 32'(s2 == 2));
            chk($sformatf("%s_c%0d_wen", ph, c), 32'(wen_o[c]), 32'(wen));
            if (wen) chk($sformatf("%s_c%0d_waddr", ph, c), 32'(wad_o[c]), 32'(m[c][2].rd));
            chk($sformatf("%s_c%0d_busy", ph, c), busy_o[c], mbusy(c));
            chk($sformatf("%s_c%0d_sel1", ph, c), 32'(sel1_o[c]), 32'(msel1[c]));
            chk($sformatf("%s_c%0d_sel2", ph, c), 32'(sel2_o[c]), 32'(msel2[c]));
        end
    endtask

    task automatic step(input string ph, input bit adv, input bit fl, input bit v,
                        input bit u1, input logic [4:0] a1, input bit u2, input logic [4:0] a2,
                        input logic [4:0] rdd, input bit we, input bit ld);
        mtag_t nt;
        pipe_adv = adv; flush = fl; id_valid = v;
        rs1_used = u1; rs1 = a1; rs2_used = u2; rs2 = a2;
        rd = rdd; rd_we = we; is_load = ld;
        #1;
        check_all({ph, "_pre"});
        if (adv) begin
            for (int c = 0; c < 2; c++) begin
                int s1  = ymatch(c, u1, int'(a1));
                int s2  = ymatch(c, u2, int'(a2));
                bit acc = v && !mstall(c) && !fl;
                nt = acc ? '{v: 1, rd: int'(rdd), we: we && rdd != 0, ld: ld}
                         : '{v: 0, rd: 0, we: 0, ld: 0};
                msel1[c] = acc ? fsel(c, s1) : 0;
                msel2[c] = acc ? fsel(c, s2) : 0;
                m[c][2] = m[c][1];
                m[c][1] = m[c][0];
                m[c][0] = nt;
            end
        end
        @(posedge clk);
        #1;
        check_all({ph, "_post"});
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; pipe_adv = 1'b0; flush = 1'b0; id_valid = 1'b0;
        rs1_used = 1'b0; rs2_used = 1'b0; rd_we = 1'b0; is_load = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
        mreset();
        @(negedge clk);
        @(negedge clk);
        check_all("rst");
        chk("rst_waddr", 32'(wad_o[0]), 32'd0);
        reset_n = 1'b1;

        // Back-to-back ALU: ADD x5 then a reader of x5
        step("add",     1, 0, 1, 0, 0, 0, 0, 5, 1, 0);
        step("add_use", 1, 0, 1, 1, 5, 0, 0, 9, 1, 0);
        chk("add_fwd_sel", 32'(sel1_o[0]), 32'd1);

        // Load-use: one stall cycle, then select from MEM/WB
        step("lw",  1, 0, 1, 0, 0, 0, 0, 6, 1, 1);
        chk("lu_stall", 32'(stall_o[0]), 32'd0);
        rs2_used = 1'b1; rs2 = 5'd6; rd = 5'd10; #1;
        chk("lu_stall_now", 32'(stall_o[0]), 32'd1);
        step("lu1", 1, 0, 1, 0, 0, 1, 6, 10, 1, 0);
        chk("lu_stall_clear", 32'(stall_o[0]), 32'd0);
        step("lu2", 1, 0, 1, 0, 0, 1, 6, 10, 1, 0);
        chk("lu_sel2", 32'(sel2_o[0]), 32'd2);

        // WB bypass: x7 writer drains to WB while ID reads x7
        step("w7",  1, 0, 1, 0, 0, 0, 0, 7, 1, 0);
        step("i1",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("i2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rs1_used = 1'b1; rs1 = 5'd7; id_valid = 1'b1; #1;
        chk("byp_flag", 32'(byp1_o[0]), 32'd1);
        chk("byp_wen", 32'(wen_o[0]), 32'd1);
        chk("byp_waddr", 32'(wad_o[0]), 32'd7);
        step("byp", 1, 0, 1, 1, 7, 0, 0, 11, 1, 0);
        chk("byp_sel", 32'(sel1_o[0]), 32'd0);

        // x0 writer and x0 reader
        step("x0w", 1, 0, 1, 1, 0, 1, 0, 0, 1, 0);
        step("x0r", 1, 0, 1, 1, 0, 1, 0, 0, 1, 1);
        step("x0i", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("x0s2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_busy", busy_o[0], 32'd0);

        // Freeze three cycles with a live reader, then a flushed writer
        step("pre_frz", 1, 0, 1, 0, 0, 0, 0, 12, 1, 0);
        for (int i = 0; i < 3; i++) step("frz", 0, 0, 1, 1, 12, 0, 0, 13, 1, 0);
        step("flush", 1, 1, 1, 0, 0, 0, 0, 14, 1, 0);
        for (int i = 0; i < 3; i++) step("drain", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Three writers in flight, a RAW reader, then async reset mid-operation
        step("wx1", 1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        step("wx2", 1, 0, 1, 0, 0, 0, 0, 2, 1, 0);
        step("wx3", 1, 0, 1, 0, 0, 0, 0, 3, 1, 0);
        step("raw", 0, 0, 1, 1, 1, 1, 3, 0, 0, 0);
        chk("raw_nofwd_stall", 32'(stall_o[1]), 32'd1);
        chk("raw_fwd_stall", 32'(stall_o[0]), 32'd0);
        pipe_adv = 1'b1; id_valid = 1'b0; #2;
        reset_n = 1'b0; #1;
        mreset();
        check_all("arst");
        chk("arst_busy", busy_o[0], 32'd0);
        chk("arst_wen", 32'(wen_o[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_hazard_scoreboard.md
Name: rf_hazard_scoreboard

Overview:
- Hazard controller for the 32x32 register file in the RV32I 5-stage pipeline.
- Tracks destination-register tags of in-flight instructions in EX, MEM and WB, and generates the ID-stage stall.
- Generates the forwarding selects registered into EX, plus the ID-stage write-back bypass.
- Owns the register-file write enable and write address driven from the WB tag.

Parameters:
- FORWARD_EN, 1: 1 = full forwarding, stall only on load-use; 0 = stall on any RAW match in EX/MEM/WB.
- NREGS, 32: architectural register count; register-address width is 5 bits.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- pipe_adv  input  1  pipeline advance; 0 freezes all stages (memory wait).
- flush  input  1  branch/jump redirect resolved in EX; squashes the ID instruction.
- id_valid  input  1  valid instruction in ID.
- id_rs1_addr  input  5  source 1 address.
- id_rs1_used  input  1  instruction reads rs1.
- id_rs2_addr  input  5  source 2 address.
- id_rs2_used  input  1  instruction reads rs2.
- id_rd_addr  input  5  destination address.
- id_rd_we  input  1  instruction writes rd.
- id_is_load  input  1  instruction is a load.
- stall  output  1  hold IF/ID; combinational.
- id_rs1_wb_bypass  output  1  ID selects WB write data for rs1; combinational.
- id_rs2_wb_bypass  output  1  ID selects WB write data for rs2; combinational.
- ex_fwd_rs1_sel  output  2  EX operand-1 source: 00 ID/EX latch, 01 EX/MEM result, 10 MEM/WB result; registered.
- ex_fwd_rs2_sel  output  2  EX operand-2 source, same encoding; registered.
- rf_wr_en  output  1  register-file write enable.
- rf_wr_addr  output  5  register-file write address.
- busy_vec  output  32  bit r = 1 when any in-flight tag writes r.

Behaviour:
- Tag pipeline: 3 stages, S0 = EX, S1 = MEM, S2 = WB. Each tag holds {valid, rd[4:0], we, is_load}.
- A tag's we is forced to 0 when its rd = 0.
- Reset (async): all tags invalid; ex_fwd_*_sel = 00; rf_wr_en = 0; rf_wr_addr = 0; busy_vec = 0; stall = 0 with id_valid = 0.
- pipe_adv = 0: every tag and ex_fwd_*_sel holds. Combinational outputs still reflect current tags.
- pipe_adv = 1: S2 <= S1, S1 <= S0.
  - S0 <= ID tag when accept = id_valid & !stall & !flush.
  - Otherwise S0 <= bubble (valid = 0).
  - A stall therefore inserts a bubble while older stages drain.
- Source match: src_used & addr != 0 & Sk.valid & Sk.we & Sk.rd == addr. Youngest match wins, priority S0 > S1 > S2.
- Stall (FORWARD_EN = 1): stall = id_valid & (any source's youngest match is S0 with is_load).
- Stall (FORWARD_EN = 0): stall = id_valid & any source matching any stage.
- flush overrides: stall is still computed, but the ID instruction is dropped regardless.
- Forward select, computed for the ID instruction from its youngest match:
  - S0 -> 01 (producer in MEM when consumer reaches EX).
  - S1 -> 10.
  - S2 or none -> 00.
  - Registered into ex_fwd_*_sel on pipe_adv: the value when accept, otherwise 00.
- With FORWARD_EN = 0, ex_fwd_*_sel is always 00.
- WB bypass: id_rsX_wb_bypass = 1 when the source's youngest match is S2. Required because the register file reads combinationally and does not see a same-cycle write.
- Register-file write port:
  - rf_wr_en = S2.valid & S2.we & pipe_adv.
  - rf_wr_addr = S2.rd.
  - Address 0 is never written.
- busy_vec: OR over the stages of decode(Sk.rd) where Sk.valid & Sk.we. Bit 0 is always 0.
- Multiple in-flight writers to the same rd are legal; priority selects the youngest.
- Reset mid-operation discards all tags immediately; no write issues after reset asserts.

Decomposition:
- Package rf_hazard_pkg holds:
  - typedef rf_tag_t {valid, rd, we, is_load};
  - enum fwd_sel_e {FWD_NONE = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10};
  - constant TAG_STAGES = 3.
- One sub-module, rf_src_match: per-source youngest-match priority encoder returning {hit, stage, is_load}. Instantiated twice (rs1, rs2).

Test Plan:
- Back-to-back ALU ops: ADD x5 accepted, then ID reads rs1 = x5 -> stall = 0; after advance, ex_fwd_rs1_sel = 01.
- Load-use: LW x6 in S0, ID reads rs2 = x6 -> stall = 1 for exactly one cycle, S0 bubble. The next cycle gives stall = 0 and registers ex_fwd_rs2_sel = 10.
- WB bypass: x7 writer in S2, ID reads rs1 = x7 -> id_rs1_wb_bypass = 1, rf_wr_en = 1, rf_wr_addr = 7, ex_fwd_rs1_sel <= 00.
- x0 handling: writer with rd = 0 and a reader of x0 -> stall = 0, selects 00, busy_vec = 0, rf_wr_en = 0 when that tag reaches S2.
- Freeze and flush: pipe_adv = 0 for 3 cycles -> tags and selects unchanged. flush = 1 with id_valid = 1 -> S0 bubble, no later write.
- Async reset asserted with 3 valid tags -> busy_vec = 0 and rf_wr_en = 0 immediately; FORWARD_EN = 0 config: any RAW match in S0..S2 -> stall = 1.
